// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the direct-mapped write-back cache controller:
//   - state_e  : controller FSM states
//   - offset_w : word-offset field width for a given words-per-line
//   - index_w  : line-index field width for a given line count
//   - tag_w    : tag field width left over from the address
//   - line_w   : width of one cache line in bits
// No ports (package).
// ---------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    REFILL    = 3'd3,
    RESPOND   = 3'd4
  } state_e;

  function automatic int offset_w(input int wordsPerLine);
    return $clog2(wordsPerLine);
  endfunction

  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int addrW, input int wordsPerLine, input int lines);
    return addrW - $clog2(wordsPerLine) - $clog2(lines);
  endfunction

  function automatic int line_w(input int dataW, input int wordsPerLine);
    return dataW * wordsPerLine;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// ---------------------------------------------------------------------------
// cache_line_store
// Tag, valid, dirty and data arrays of the direct-mapped cache, with one
// asynchronous read port and one synchronous write port.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset, clears valid/dirty only
//   rd_index_i    line index to read
//   rd_valid_o    valid bit of the read line
//   rd_dirty_o    dirty bit of the read line
//   rd_tag_o      stored tag of the read line
//   rd_data_o     stored data of the read line
//   we_i          write enable (writes tag/data, sets valid, loads dirty)
//   wr_index_i    line index to write
//   wr_tag_i      tag to store
//   wr_dirty_i    dirty value to store
//   wr_data_i     line data to store
// ---------------------------------------------------------------------------
module cache_line_store
  import cache_pkg::*;
#(
  parameter int LINES  = 32,
  parameter int TAG_W  = 2,
  parameter int LINE_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [index_w(LINES)-1:0]  rd_index_i,
  output logic                       rd_valid_o,
  output logic                       rd_dirty_o,
  output logic [TAG_W-1:0]           rd_tag_o,
  output logic [LINE_W-1:0]          rd_data_o,
  input  logic                       we_i,
  input  logic [index_w(LINES)-1:0]  wr_index_i,
  input  logic [TAG_W-1:0]           wr_tag_i,
  input  logic                       wr_dirty_i,
  input  logic [LINE_W-1:0]          wr_data_i
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  // Status bits are the only state that reset touches; every write marks
  // the line valid and loads the caller's view of whether it is dirty.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
      dirty_q[wr_index_i] <= wr_dirty_i;
    end
  end

  // Tag and data storage keep their contents across reset; a cleared valid
  // bit is enough to make stale contents invisible.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/cache_ctrl_param.sv
// ---------------------------------------------------------------------------
// cache_ctrl_param
// Direct-mapped, write-back / write-allocate cache controller sitting between
// a word-oriented processor port and a line-oriented memory port.
// Optional build macro: CACHE_STATS_EN adds saturating hit/miss counters.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   p_req         processor request (sampled only in IDLE)
//   p_wen         1 = write, 0 = read
//   p_address     word address {tag,index,offset}
//   p_wdata       write data
//   p_rdata       read data of the last completed read
//   p_ready       one-cycle completion pulse
//   is_hit        hit/miss of the last completed access
//   busy          high whenever the controller is not IDLE
//   mem_req       memory request
//   mem_wen       1 = line write-back, 0 = line fetch
//   mem_address   line address {tag,index}
//   mem_wdata     victim line for write-back
//   mem_rdata     fetched line, word k at [k*DATA_W +: DATA_W]
//   mem_ack       single-cycle memory completion
//   hit_count     (CACHE_STATS_EN) completed hits, saturating
//   miss_count    (CACHE_STATS_EN) completed misses, saturating
// ---------------------------------------------------------------------------
module cache_ctrl_param
  import cache_pkg::*;
#(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          p_req,
  input  logic                                          p_wen,
  input  logic [ADDR_W-1:0]                             p_address,
  input  logic [DATA_W-1:0]                             p_wdata,
  output logic [DATA_W-1:0]                             p_rdata,
  output logic                                          p_ready,
  output logic                                          is_hit,
  output logic                                          busy,
  output logic                                          mem_req,
  output logic                                          mem_wen,
  output logic [ADDR_W-offset_w(WORDS_PER_LINE)-1:0]    mem_address,
  output logic [line_w(DATA_W, WORDS_PER_LINE)-1:0]     mem_wdata,
  input  logic [line_w(DATA_W, WORDS_PER_LINE)-1:0]     mem_rdata,
  input  logic                                          mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                                   hit_count,
  output logic [15:0]                                   miss_count
`endif
);

  localparam int OFF_W  = offset_w(WORDS_PER_LINE);
  localparam int IDX_W  = index_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, WORDS_PER_LINE, LINES);
  localparam int LINE_W = line_w(DATA_W, WORDS_PER_LINE);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                hit_q, hit_d;

  logic [TAG_W-1:0]    curTag;
  logic [IDX_W-1:0]    curIndex;
  logic [OFF_W-1:0]    curOffset;
  int                  wordBase;

  logic                rdValid;
  logic                rdDirty;
  logic [TAG_W-1:0]    rdTag;
  logic [LINE_W-1:0]   rdLine;

  logic                lineHit;
  logic [LINE_W-1:0]   mergedHit;
  logic [LINE_W-1:0]   mergedFill;
  logic                storeWe;
  logic                storeDirty;
  logic [LINE_W-1:0]   storeLine;

  assign curTag    = addr_q[ADDR_W-1 -: TAG_W];
  assign curIndex  = addr_q[OFF_W +: IDX_W];
  assign curOffset = addr_q[OFF_W-1:0];
  assign wordBase  = int'(curOffset) * DATA_W;

  cache_line_store #(
    .LINES  (LINES),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (curIndex),
    .rd_valid_o (rdValid),
    .rd_dirty_o (rdDirty),
    .rd_tag_o   (rdTag),
    .rd_data_o  (rdLine),
    .we_i       (storeWe),
    .wr_index_i (curIndex),
    .wr_tag_i   (curTag),
    .wr_dirty_i (storeDirty),
    .wr_data_i  (storeLine)
  );

  assign lineHit = rdValid && (rdTag == curTag);

  // Write data is merged into either the resident line (write hit) or the
  // freshly fetched line (write miss), so allocation and update happen in a
  // single store write.
  always_comb begin
    mergedHit  = rdLine;
    mergedFill = mem_rdata;
    mergedHit[wordBase +: DATA_W]  = wdata_q;
    mergedFill[wordBase +: DATA_W] = wdata_q;
  end

  // Next-state and store-write control. p_rdata/is_hit are loaded only on
  // the transition into RESPOND so they stay stable until the next access
  // completes. mem_ack is only looked at in the two memory states, which is
  // what makes a stray acknowledge harmless.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    storeWe    = 1'b0;
    storeDirty = 1'b0;
    storeLine  = rdLine;
    unique case (state_q)
      IDLE: begin
        if (p_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (lineHit) begin
          state_d = RESPOND;
          hit_d   = 1'b1;
          if (wen_q) begin
            storeWe    = 1'b1;
            storeDirty = 1'b1;
            storeLine  = mergedHit;
          end else begin
            rdata_d = rdLine[wordBase +: DATA_W];
          end
        end else if (rdValid && rdDirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_ack) state_d = REFILL;
      end
      REFILL: begin
        if (mem_ack) begin
          state_d    = RESPOND;
          hit_d      = 1'b0;
          storeWe    = 1'b1;
          storeDirty = wen_q;
          storeLine  = wen_q ? mergedFill : mem_rdata;
          if (!wen_q) rdata_d = mem_rdata[wordBase +: DATA_W];
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus the request capture; the request is latched only on
  // the accepting edge so later p_address/p_wdata activity cannot disturb an
  // access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      if (state_q == IDLE && p_req) begin
        addr_q  <= p_address;
        wen_q   <= p_wen;
        wdata_q <= p_wdata;
      end
    end
  end

  assign p_rdata     = rdata_q;
  assign is_hit      = hit_q;
  assign p_ready     = (state_q == RESPOND);
  assign busy        = (state_q != IDLE);
  assign mem_req     = (state_q == WRITEBACK) || (state_q == REFILL);
  assign mem_wen     = (state_q == WRITEBACK);
  assign mem_address = (state_q == WRITEBACK) ? {rdTag, curIndex} : {curTag, curIndex};
  assign mem_wdata   = rdLine;

`ifdef CACHE_STATS_EN
  logic [15:0] hitCount_q;
  logic [15:0] missCount_q;

  // One count per completed access, taken during the RESPOND cycle when
  // hit_q already reflects the access that is finishing.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else if (state_q == RESPOND) begin
      if (hit_q) begin
        if (hitCount_q != 16'hFFFF) hitCount_q <= hitCount_q + 16'd1;
      end else begin
        if (missCount_q != 16'hFFFF) missCount_q <= missCount_q + 16'd1;
      end
    end
  end

  assign hit_count  = hitCount_q;
  assign miss_count = missCount_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_param
// Directed self-checking bench for cache_ctrl_param at default parameters.
// Expected processor responses are queued when a request is driven and
// compared when p_ready appears; memory-side traffic is checked as it is
// served. Build with CACHE_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_param;

  logic        clk;
  logic        rst;
  logic        p_req;
  logic        p_wen;
  logic [8:0]  p_address;
  logic [7:0]  p_wdata;
  logic [7:0]  p_rdata;
  logic        p_ready;
  logic        is_hit;
  logic        busy;
  logic        mem_req;
  logic        mem_wen;
  logic [6:0]  mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  typedef struct packed {
    logic [7:0] rdata;
    logic       hit;
  } exp_t;

  exp_t sbQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   failCount  = 0;

  cache_ctrl_param dut (
    .clk         (clk),
    .rst         (rst),
    .p_req       (p_req),
    .p_wen       (p_wen),
    .p_address   (p_address),
    .p_wdata     (p_wdata),
    .p_rdata     (p_rdata),
    .p_ready     (p_ready),
    .is_hit      (is_hit),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_wen     (mem_wen),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count)
`endif
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives a one-cycle request and queues the response it should produce.
  task automatic applyStimulus(input logic wen, input logic [8:0] addr,
                               input logic [7:0] wdata, input logic [7:0] expRdata,
                               input logic expHit);
    exp_t e;
    p_req     = 1'b1;
    p_wen     = wen;
    p_address = addr;
    p_wdata   = wdata;
    e.rdata   = expRdata;
    e.hit     = expHit;
    sbQ.push_back(e);
    tick();
    p_req = 1'b0;
  endtask

  // Waits (bounded) for a memory request, checks it, then acknowledges it
  // after the given number of cycles with the supplied line.
  task automatic serveMem(input string tag, input logic expWen, input logic [6:0] expAddr,
                          input logic [31:0] expWdata, input logic [31:0] line,
                          input int latency);
    int n;
    n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
    if (mem_req) begin
      checkOutput({tag, "_mem_wen"}, {31'd0, mem_wen}, {31'd0, expWen});
      checkOutput({tag, "_mem_addr"}, {25'd0, mem_address}, {25'd0, expAddr});
      if (expWen) checkOutput({tag, "_mem_wdata"}, mem_wdata, expWdata);
      for (int i = 0; i < latency; i++) begin
        tick();
        checkOutput({tag, "_mem_req_hold"}, {31'd0, mem_req}, 32'd1);
      end
      mem_ack   = 1'b1;
      mem_rdata = line;
      tick();
      mem_ack   = 1'b0;
    end
  endtask

  // Waits (bounded) for p_ready, compares against the scoreboard head and
  // checks the pulse lasts one cycle. expLat>0 also checks the number of
  // falling edges from the request drive to p_ready. reqInRespond holds
  // p_req high during RESPOND to confirm it is not accepted.
  task automatic waitReady(input string tag, input int expLat, input logic reqInRespond);
    int   waited;
    exp_t e;
    waited = 0;
    while (!p_ready && waited < 200) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_p_ready"}, {31'd0, p_ready}, 32'd1);
    checkOutput({tag, "_sb_size"}, sbQ.size(), 32'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, "_p_rdata"}, {24'd0, p_rdata}, {24'd0, e.rdata});
      checkOutput({tag, "_is_hit"}, {31'd0, is_hit}, {31'd0, e.hit});
    end
    if (expLat > 0) checkOutput({tag, "_latency"}, waited + 1, expLat);
    if (reqInRespond) begin
      p_req     = 1'b1;
      p_wen     = 1'b0;
      p_address = 9'h005;
    end
    tick();
    checkOutput({tag, "_pulse_end"}, {31'd0, p_ready}, 32'd0);
    if (reqInRespond) begin
      checkOutput({tag, "_respond_req_ignored"}, {31'd0, busy}, 32'd0);
      p_req = 1'b0;
      tick();
      checkOutput({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    p_req     = 1'b0;
    p_wen     = 1'b0;
    p_address = '0;
    p_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    repeat (2) tick();

    // Reset state.
    checkOutput("rst_busy",    {31'd0, busy},    32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_p_ready", {31'd0, p_ready}, 32'd0);
    checkOutput("rst_is_hit",  {31'd0, is_hit},  32'd0);
    checkOutput("rst_p_rdata", {24'd0, p_rdata}, 32'd0);
    rst = 1'b0;
    tick();

    // Cold read miss then a hit in the same line.
    applyStimulus(1'b0, 9'h004, 8'h00, 8'h04, 1'b0);
    serveMem("miss004", 1'b0, 7'h01, 32'h0, 32'h07060504, 3);
    waitReady("miss004", 0, 1'b0);
    applyStimulus(1'b0, 9'h005, 8'h00, 8'h05, 1'b1);
    waitReady("hit005", 2, 1'b0);
`ifdef CACHE_STATS_EN
    checkOutput("stats_hit",  {16'd0, hit_count},  32'd1);
    checkOutput("stats_miss", {16'd0, miss_count}, 32'd1);
`endif

    // Write hit dirties line 1; conflicting read writes it back then refills.
    applyStimulus(1'b1, 9'h005, 8'hAA, 8'h05, 1'b1);
    waitReady("whit005", 2, 1'b0);
    checkOutput("whit_no_mem", {31'd0, mem_req}, 32'd0);
    applyStimulus(1'b0, 9'h085, 8'h00, 8'h19, 1'b0);
    serveMem("wb085", 1'b1, 7'h01, 32'h0706AA04, 32'h0, 2);
    serveMem("fill085", 1'b0, 7'h21, 32'h0, 32'h1B1A1918, 1);
    waitReady("rd085", 0, 1'b0);

    // Write miss allocates line 4 dirty; an evicting read writes it back.
    applyStimulus(1'b1, 9'h010, 8'h5C, 8'h19, 1'b0);
    serveMem("fill010", 1'b0, 7'h04, 32'h0, 32'h13121110, 2);
    waitReady("wmiss010", 0, 1'b0);
    applyStimulus(1'b0, 9'h090, 8'h00, 8'h20, 1'b0);
    serveMem("wb090", 1'b1, 7'h04, 32'h1312115C, 32'h0, 1);
    serveMem("fill090", 1'b0, 7'h24, 32'h0, 32'h23222120, 0);
    waitReady("rd090", 0, 1'b0);
    applyStimulus(1'b0, 9'h091, 8'h00, 8'h21, 1'b1);
    waitReady("hit091", 2, 1'b0);

    // Reset in the middle of a refill; a late ack must be ignored.
    applyStimulus(1'b0, 9'h104, 8'h00, 8'h00, 1'b0);
    n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    checkOutput("midrst_req",  {31'd0, mem_req}, 32'd1);
    checkOutput("midrst_addr", {25'd0, mem_address}, 32'h41);
    checkOutput("midrst_wen",  {31'd0, mem_wen}, 32'd0);
    rst = 1'b1;
    tick();
    checkOutput("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("midrst_busy",    {31'd0, busy},    32'd0);
    checkOutput("midrst_p_ready", {31'd0, p_ready}, 32'd0);
    checkOutput("midrst_is_hit",  {31'd0, is_hit},  32'd0);
    checkOutput("midrst_p_rdata", {24'd0, p_rdata}, 32'd0);
    sbQ.delete();
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack   = 1'b0;
    checkOutput("lateack_busy",    {31'd0, busy},    32'd0);
    checkOutput("lateack_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("lateack_p_ready", {31'd0, p_ready}, 32'd0);
    applyStimulus(1'b0, 9'h005, 8'h00, 8'h05, 1'b0);
    serveMem("reread005", 1'b0, 7'h01, 32'h0, 32'h07060504, 0);
    waitReady("reread005", 0, 1'b0);

    // Long memory stall while p_req keeps pulsing.
    applyStimulus(1'b0, 9'h0C8, 8'h00, 8'h38, 1'b0);
    n = 0;
    while (!mem_req && n < 50) begin
      tick();
      n++;
    end
    checkOutput("stall_req_up", {31'd0, mem_req}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      p_req     = (i % 2 == 0);
      p_wen     = 1'b1;
      p_address = 9'h1FF;
      p_wdata   = 8'hEE;
      tick();
      checkOutput("stall_busy",    {31'd0, busy},        32'd1);
      checkOutput("stall_mem_addr", {25'd0, mem_address}, 32'h32);
    end
    p_req     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h3B3A3938;
    tick();
    mem_ack   = 1'b0;
    waitReady("stall0C8", 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("post_stall_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("post_stall_busy",    {31'd0, busy},    32'd0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
